// File: rtl/proj_select_hub.sv
// proj_select_hub: routes one of N_PROJ project pad buses to the pads, with a
// debounced select, a blank-and-reset switch sequence and registered outputs.
// Latency: 1 cycle proj_out->io_out in LIVE; 1+BLANK_CYC+SETTLE_CYC cycles from
// a select change to first live data. No backpressure: pads sample every cycle.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   sel             requested project
//   proj_out/oeb    concatenated project pad data / output enables, WIDTH each
//   io_out/io_oeb   registered pad data / output enable (1 = hi-Z)
//   proj_rst_n      per-project active-low reset
//   active_sel      committed select
//   switching       high during BLANK and RELEASE
//   sel_err         high while the committed select is out of range
module proj_select_hub #(
  parameter int N_PROJ       = 11,
  parameter int WIDTH        = 16,
  parameter int SEL_W        = 4,
  parameter int BLANK_CYC    = 2,
  parameter int SETTLE_CYC   = 4,
  parameter int RST_INACTIVE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          sel,
  input  logic [N_PROJ*WIDTH-1:0]   proj_out,
  input  logic [N_PROJ*WIDTH-1:0]   proj_oeb,
  output logic [WIDTH-1:0]          io_out,
  output logic [WIDTH-1:0]          io_oeb,
  output logic [N_PROJ-1:0]         proj_rst_n,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      switching,
  output logic                      sel_err
);

  localparam int CNT_MAX = (BLANK_CYC > SETTLE_CYC) ? BLANK_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  // One extra bit so N_PROJ == 2**SEL_W is representable.
  localparam logic [SEL_W:0]   N_PROJ_EXT  = (SEL_W+1)'(N_PROJ);

  typedef enum logic [1:0] {
    ST_BLANK   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_LIVE    = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   sel_q;

  logic               sel_in_range;
  logic               accept;
  logic [WIDTH-1:0]   live_out;
  logic [WIDTH-1:0]   live_oeb;
  logic [N_PROJ-1:0]  run_mask;

  assign sel_in_range = ({1'b0, sel} < N_PROJ_EXT);

  // A select must be stable for two consecutive edges before it is taken.
  // Re-selecting the committed value is only meaningful to leave ERR.
  assign accept = (sel == sel_q) &&
                  ((sel != active_sel) || ((state_q == ST_ERR) && sel_in_range));

  // Explicit compare-mux rather than a variable part-select so an out-of-range
  // committed select can never index past the concatenated buses.
  always_comb begin
    live_out = '0;
    live_oeb = '0;
    run_mask = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (active_sel == SEL_W'(k)) begin
        live_out = proj_out[k*WIDTH +: WIDTH];
        live_oeb = proj_oeb[k*WIDTH +: WIDTH];
      end
      run_mask[k] = (active_sel == SEL_W'(k)) || (RST_INACTIVE == 0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      sel_q      <= '0;
      active_sel <= '0;
      io_out     <= '0;
      io_oeb     <= '1;
      proj_rst_n <= '0;
      switching  <= 1'b1;
      sel_err    <= 1'b0;
    end else begin
      sel_q <= sel;
      if (accept) begin
        // A new select restarts the sequence from any state.
        active_sel <= sel;
        cnt_q      <= '0;
        io_out     <= '0;
        io_oeb     <= '1;
        proj_rst_n <= '0;
        if (sel_in_range) begin
          state_q   <= ST_BLANK;
          switching <= 1'b1;
          sel_err   <= 1'b0;
        end else begin
          state_q   <= ST_ERR;
          switching <= 1'b0;
          sel_err   <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q    <= ST_RELEASE;
              cnt_q      <= '0;
              proj_rst_n <= run_mask;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (cnt_q == SETTLE_LAST) begin
              // First live sample is taken on the edge that enters LIVE.
              state_q   <= ST_LIVE;
              cnt_q     <= '0;
              switching <= 1'b0;
              io_out    <= live_out;
              io_oeb    <= live_oeb;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_LIVE: begin
            io_out <= live_out;
            io_oeb <= live_oeb;
          end
          ST_ERR: begin
            // Held blanked until an in-range select is accepted.
          end
          default: begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            io_out     <= '0;
            io_oeb     <= '1;
            proj_rst_n <= '0;
            switching  <= 1'b1;
            sel_err    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_proj_select_hub.sv
module tb_proj_select_hub;

  localparam int NP = 11;
  localparam int W  = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b;
  logic [SW-1:0]     sel_a, sel_b;
  logic [NP*W-1:0]   pout, poeb;

  logic [W-1:0]      io_out_a, io_oeb_a, io_out_b, io_oeb_b;
  logic [NP-1:0]     rst_n_a, rst_n_b;
  logic [SW-1:0]     asel_a, asel_b;
  logic              sw_a, sw_b, err_a, err_b;

  proj_select_hub #(
    .N_PROJ(NP), .WIDTH(W), .SEL_W(SW), .BLANK_CYC(2), .SETTLE_CYC(4), .RST_INACTIVE(1)
  ) u_a (
    .clk(clk), .rst(rst_a), .sel(sel_a), .proj_out(pout), .proj_oeb(poeb),
    .io_out(io_out_a), .io_oeb(io_oeb_a), .proj_rst_n(rst_n_a),
    .active_sel(asel_a), .switching(sw_a), .sel_err(err_a)
  );

  proj_select_hub #(
    .N_PROJ(NP), .WIDTH(W), .SEL_W(SW), .BLANK_CYC(2), .SETTLE_CYC(4), .RST_INACTIVE(0)
  ) u_b (
    .clk(clk), .rst(rst_b), .sel(sel_b), .proj_out(pout), .proj_oeb(poeb),
    .io_out(io_out_b), .io_oeb(io_oeb_b), .proj_rst_n(rst_n_b),
    .active_sel(asel_b), .switching(sw_b), .sel_err(err_b)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [15:0] o;
    logic [15:0] oe;
    logic [10:0] rn;
    logic        sw;
    logic        er;
    logic [3:0]  asel;
  } exp_t;

  exp_t        sbq[$];
  int          edge_n = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] dat_tbl [NP];
  logic [15:0] oeb_tbl [NP];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int cyc, input int dut, input logic [15:0] o, input logic [15:0] oe,
                      input logic [10:0] rn, input logic sw, input logic er, input logic [3:0] asel);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.o = o; e.oe = oe; e.rn = rn;
    e.sw = sw; e.er = er; e.asel = asel;
    sbq.push_back(e);
  endtask

  function automatic logic [10:0] run_mask(input int dut, input int p);
    return (dut == 1) ? 11'h7FF : (11'h001 << p);
  endfunction

  task automatic exp_blank(input int cyc, input int dut, input int asel);
    push(cyc, dut, 16'h0000, 16'hFFFF, 11'h000, 1'b1, 1'b0, 4'(asel));
  endtask

  task automatic exp_live(input int cyc, input int dut, input int p);
    push(cyc, dut, dat_tbl[p], oeb_tbl[p], run_mask(dut, p), 1'b0, 1'b0, 4'(p));
  endtask

  task automatic exp_err(input int cyc, input int asel);
    push(cyc, 0, 16'h0000, 16'hFFFF, 11'h000, 1'b0, 1'b1, 4'(asel));
  endtask

  // Acceptance (or reset release) at edge a: 2 blank, 4 release, then live.
  task automatic exp_seq(input int dut, input int a, input int p);
    exp_blank(a, dut, p);
    exp_blank(a + 1, dut, p);
    for (int c = a + 2; c <= a + 5; c++)
      push(c, dut, 16'h0000, 16'hFFFF, run_mask(dut, p), 1'b1, 1'b0, 4'(p));
    exp_live(a + 6, dut, p);
    exp_live(a + 7, dut, p);
  endtask

  task automatic check(input exp_t e);
    logic [15:0] o, oe;
    logic [10:0] rn;
    logic        sw, er;
    logic [3:0]  asel;
    if (e.dut == 0) begin
      o = io_out_a; oe = io_oeb_a; rn = rst_n_a; sw = sw_a; er = err_a; asel = asel_a;
    end else begin
      o = io_out_b; oe = io_oeb_b; rn = rst_n_b; sw = sw_b; er = err_b; asel = asel_b;
    end
    checks++;
    if (e.cyc != edge_n || o !== e.o || oe !== e.oe || rn !== e.rn ||
        sw !== e.sw || er !== e.er || asel !== e.asel) begin
      errors++;
      $display("FAIL dut%0d cyc%0d (at %0d): got out=%h oeb=%h rst_n=%h sw=%b err=%b asel=%0d, want out=%h oeb=%h rst_n=%h sw=%b err=%b asel=%0d",
               e.dut, e.cyc, edge_n, o, oe, rn, sw, er, asel,
               e.o, e.oe, e.rn, e.sw, e.er, e.asel);
    end
  endtask

  // Monitor: compares every expectation that falls due at this sample point.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= edge_n) begin
        check(sbq[i]);
        sbq.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    for (int p = 0; p < NP; p++) begin
      dat_tbl[p] = 16'(32'h1111 * p);
      oeb_tbl[p] = 16'(p);
    end
    dat_tbl[0] = 16'hA55A;
    dat_tbl[3] = 16'h1234;
    for (int p = 0; p < NP; p++) begin
      pout[p*W +: W] = dat_tbl[p];
      poeb[p*W +: W] = oeb_tbl[p];
    end
    rst_a = 1'b0; rst_b = 1'b0;
    sel_a = 4'd0; sel_b = 4'd1;

    // Reset values, then release: sequence to project 0.
    step(2);
    k = edge_n;
    exp_blank(k, 1, 0);
    rst_a = 1'b1;
    exp_seq(0, k, 0);
    step(9);

    // One-cycle glitch to 5 is ignored.
    k = edge_n;
    sel_a = 4'd5;
    for (int c = 1; c <= 4; c++) exp_live(k + c, 0, 0);
    step(1);
    sel_a = 4'd0;
    step(4);

    // Switch 0 -> 3.
    k = edge_n;
    sel_a = 4'd3;
    exp_live(k + 1, 0, 0);
    exp_seq(0, k + 2, 3);
    step(9);

    // Out-of-range 12, then recover onto 2.
    k = edge_n;
    sel_a = 4'd12;
    exp_live(k + 1, 0, 3);
    exp_err(k + 2, 12);
    exp_err(k + 3, 12);
    exp_seq(0, k + 4, 2);
    step(2);
    sel_a = 4'd2;
    step(9);

    // 2 -> 4, then 7 one cycle into BLANK: 4 never released.
    k = edge_n;
    sel_a = 4'd4;
    exp_live(k + 1, 0, 2);
    exp_blank(k + 2, 0, 4);
    exp_blank(k + 3, 0, 4);
    exp_seq(0, k + 4, 7);
    step(2);
    sel_a = 4'd7;
    step(9);

    // RST_INACTIVE=0 instance: live on 1 with all resets released.
    k = edge_n;
    exp_blank(k, 1, 0);
    rst_b = 1'b1;
    exp_blank(k + 1, 1, 0);
    exp_seq(1, k + 2, 1);
    step(10);

    // Asynchronous reset between edges.
    k = edge_n;
    rst_b = 1'b0;
    exp_blank(k, 1, 0);
    exp_blank(k + 1, 1, 0);
    step(3);

    if (sbq.size() != 0) begin
      checks += sbq.size();
      errors += sbq.size();
      $display("FAIL scoreboard: %0d expectations never compared, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proj_select_hub.md
Name: proj_select_hub

Overview:
- Parametrised successor to the project-output multiplexer in the shared user area. It routes one of N_PROJ student-project output buses to the pad outputs.
- Unlike a plain combinational mux, it debounces the select and registers the outputs. Each project switch follows a blank-and-reset sequence, so pads never see a mix of two projects' signals.
- It gates each project's active-low reset, checks that the select is in range, and passes through each project's own output-enable (oeb) bus.

Parameters:
- N_PROJ, 11: number of project channels; must satisfy 1 <= N_PROJ <= 2**SEL_W.
- WIDTH, 16: pad bus width per project.
- SEL_W, 4: select width.
- BLANK_CYC, 2: cycles the pads are tri-stated and all projects held in reset during a switch; must be >= 1.
- SETTLE_CYC, 4: cycles after the newly selected project is released from reset and before its outputs reach the pads; must be >= 1.
- RST_INACTIVE, 1: 1 = unselected projects are held in reset; 0 = unselected projects run freely, and only the switch sequence resets them.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- sel  in  SEL_W  requested project (from the wishbone select lines).
- proj_out  in  N_PROJ*WIDTH  concatenated project outputs; project k occupies bits [k*WIDTH +: WIDTH].
- proj_oeb  in  N_PROJ*WIDTH  concatenated project output enables, same packing as proj_out.
- io_out  out  WIDTH  registered pad data.
- io_oeb  out  WIDTH  registered pad output enable; 1 = input/hi-Z.
- proj_rst_n  out  N_PROJ  per-project active-low reset.
- active_sel  out  SEL_W  currently committed select.
- switching  out  1  high while in BLANK or RELEASE.
- sel_err  out  1  high while in ERR (committed select out of range).

Behaviour:
- Reset values (while rst=0):
  - io_out=0, io_oeb=all 1, proj_rst_n=all 0.
  - active_sel=0, switching=1, sel_err=0, sel_q=0.
  - State=BLANK with counter=0, i.e. a switch to project 0 in progress.
- Select debounce:
  - sel_q <= sel on every edge.
  - A select is accepted on an edge where sel==sel_q and any of the following holds:
    - sel != active_sel; or
    - state is ERR and sel is in range.
  - A 1-cycle sel glitch is never accepted.
- On acceptance:
  - active_sel <= sel and counter <= 0.
  - If sel < N_PROJ: go to BLANK. Otherwise: go to ERR.
  - Takes priority over every state, including mid-BLANK and mid-RELEASE; the sequence restarts from the beginning.
- BLANK:
  - io_out=0, io_oeb=all 1, proj_rst_n=all 0, switching=1.
  - After BLANK_CYC edges, go to RELEASE with counter=0.
- RELEASE:
  - proj_rst_n[active_sel]=1.
  - Other bits are 0 if RST_INACTIVE=1, else 1.
  - Pads stay blanked and switching=1.
  - After SETTLE_CYC edges, go to LIVE.
- LIVE:
  - switching=0.
  - Every edge: io_out <= proj_out slice[active_sel] and io_oeb <= proj_oeb slice[active_sel]; latency is 1 cycle.
  - The first live sample is registered on the edge that enters LIVE.
  - The selected project's reset is released. Unselected projects are held in reset if RST_INACTIVE=1, else released.
- ERR:
  - Pads blanked, proj_rst_n=all 0, switching=0, sel_err=1.
  - Leave only by accepting an in-range select, which goes to BLANK.
- Switch timing: total from the sel change to the first live pad data = 1 (debounce) + BLANK_CYC + SETTLE_CYC edges.
- Mid-operation reset: asserting rst in any state immediately forces the reset values above, without waiting for a clock edge.
- Counter width: $clog2(max(BLANK_CYC, SETTLE_CYC)+1); counters never wrap.
- No combinational path from any input to any output.

Test Plan:
- Reset, defaults (N_PROJ=11, WIDTH=16, BLANK_CYC=2, SETTLE_CYC=4), sel=0, proj_out slice0=16'hA55A, slice0 oeb=0, rst released at edge E:
  - proj_rst_n=11'h001 from E+2; switching falls and io_out=16'hA55A, io_oeb=0 at E+6.
- From LIVE on 0, sel changes to 3 before edge T with slice3=16'h1234:
  - Accepted at T+1: io_oeb=all 1 and proj_rst_n=0 at T+1.
  - proj_rst_n=11'h008 at T+3.
  - io_out=16'h1234 and switching=0 at T+7.
- sel pulses 0→5→0 for one cycle only:
  - active_sel stays 0, switching stays 0, io_out never blanks.
- sel=12, held 2 cycles:
  - sel_err=1, pads blanked, proj_rst_n=0, active_sel=12.
  - Then sel=2: sel_err clears on acceptance, full BLANK/RELEASE sequence, LIVE on project 2.
- sel changes 0→4, then 4→7 one cycle into BLANK:
  - Counter restarts, project 4 is never released, LIVE on project 7 after a full sequence.
- RST_INACTIVE=0, LIVE on 1:
  - proj_rst_n=all 1.
  - Assert rst mid-LIVE without a clock edge: outputs go to reset values immediately.
